// File: rtl/gpu_cmd_unit.sv
// GPU command executor: handshaked commands over a double-buffered RGB565 frame buffer.
// Optional build macro GPU_PERF_EN adds the perf_cycles busy-cycle counter output.
module gpu_cmd_unit #(
    parameter int FB_WORDS = 4800,
    parameter int ADDR_W   = 13
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [2:0]        command,
    input  logic [1:0]        command_ready,
    output logic [1:0]        command_received,
    input  logic [15:0]       op_a,
    input  logic [15:0]       op_b,
    output logic [ADDR_W:0]   fb_addr,
    output logic              fb_re,
    input  logic [15:0]       fb_rdata,
    output logic              fb_we,
    output logic [15:0]       fb_wdata,
    output logic              front_sel,
    output logic              busy
`ifdef GPU_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    localparam logic [2:0] CMD_WPIX  = 3'b000;
    localparam logic [2:0] CMD_INV   = 3'b001;
    localparam logic [2:0] CMD_GRSC  = 3'b010;
    localparam logic [2:0] CMD_BRTN  = 3'b011;
    localparam logic [2:0] CMD_RANGE = 3'b100;
    localparam logic [2:0] CMD_PUB   = 3'b110;

    localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(FB_WORDS - 1);
    localparam logic [ADDR_W:0]   FB_WORDS_W = (ADDR_W + 1)'(FB_WORDS);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WPIX = 3'd1,
        S_RD   = 3'd2,
        S_WR   = 3'd3,
        S_ACK  = 3'd4,
        S_FIN  = 3'd5
    } state_t;

    state_t              state_r, state_s;
    logic [2:0]          cmd_r;
    logic [ADDR_W-1:0]   op_a_idx_r;
    logic [5:0]          op_a_lo_r;
    logic [15:0]         op_b_r;
    logic [ADDR_W-1:0]   idx_r, idx_s;
    logic                front_sel_r;
    logic                latch_s;
    logic                toggle_s;
    logic                wpix_ok_s;

    // Brightness: channel plus signed offset, clamped to the 6-bit range.
    function automatic logic [5:0] sat_add(input logic [5:0] c, input logic [5:0] d);
        logic signed [7:0] s;
        s = $signed({2'b00, c}) + $signed({{2{d[5]}}, d});
        if (s < 8'sd0) begin
            sat_add = 6'd0;
        end else if (s > 8'sd63) begin
            sat_add = 6'd63;
        end else begin
            sat_add = s[5:0];
        end
    endfunction

    function automatic logic [5:0] clamp6(input logic [5:0] c, input logic [5:0] lo,
                                          input logic [5:0] hi);
        if (lo > hi) begin
            clamp6 = hi;
        end else if (c < lo) begin
            clamp6 = lo;
        end else if (c > hi) begin
            clamp6 = hi;
        end else begin
            clamp6 = c;
        end
    endfunction

    // Channels are handled at 6 bits; R and B widen by replicating their MSB.
    function automatic logic [15:0] pixel_op(input logic [2:0] cmd, input logic [15:0] p,
                                             input logic [5:0] a, input logic [5:0] b);
        logic [5:0] r6, g6, b6, y;
        logic [7:0] sum;
        logic [5:0] rn, gn, bn;
        r6  = {p[15:11], p[15]};
        g6  = p[10:5];
        b6  = {p[4:0], p[4]};
        sum = {2'b00, r6} + {1'b0, g6, 1'b0} + {2'b00, b6};
        y   = 6'(sum >> 2);
        rn  = 6'd0;
        gn  = 6'd0;
        bn  = 6'd0;
        case (cmd)
            CMD_INV:  pixel_op = ~p;
            CMD_GRSC: pixel_op = {y[5:1], y, y[5:1]};
            CMD_BRTN: begin
                rn = sat_add(r6, a);
                gn = sat_add(g6, a);
                bn = sat_add(b6, a);
                pixel_op = {rn[5:1], gn, bn[5:1]};
            end
            CMD_RANGE: begin
                rn = clamp6(r6, a, b);
                gn = clamp6(g6, a, b);
                bn = clamp6(b6, a, b);
                pixel_op = {rn[5:1], gn, bn[5:1]};
            end
            default:  pixel_op = p;
        endcase
    endfunction

    // Next-state logic; the command and operands only matter in IDLE.
    always_comb begin
        state_s  = state_r;
        idx_s    = idx_r;
        latch_s  = 1'b0;
        toggle_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                if (command_ready == 2'b01) begin
                    latch_s = 1'b1;
                    idx_s   = {ADDR_W{1'b0}};
                    case (command)
                        CMD_WPIX:                              state_s = S_WPIX;
                        CMD_INV, CMD_GRSC, CMD_BRTN, CMD_RANGE: state_s = S_RD;
                        CMD_PUB: begin
                            toggle_s = 1'b1;
                            state_s  = S_ACK;
                        end
                        default:                               state_s = S_ACK;
                    endcase
                end else if (command_ready == 2'b10) begin
                    state_s = S_FIN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WPIX: state_s = S_ACK;
            S_RD:   state_s = S_WR;
            S_WR: begin
                if (idx_r == LAST_IDX) begin
                    state_s = S_ACK;
                end else begin
                    idx_s   = idx_r + ADDR_W'(1);
                    state_s = S_RD;
                end
            end
            S_ACK: begin
                if (command_ready == 2'b01) begin
                    state_s = S_ACK;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_FIN: begin
                if (command_ready == 2'b10) begin
                    state_s = S_FIN;
                end else begin
                    state_s = S_IDLE;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // State, pixel index, latched operands and displayed-buffer select.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r     <= S_IDLE;
            idx_r       <= {ADDR_W{1'b0}};
            cmd_r       <= 3'b111;
            op_a_idx_r  <= {ADDR_W{1'b0}};
            op_a_lo_r   <= 6'd0;
            op_b_r      <= 16'h0000;
            front_sel_r <= 1'b0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
            if (latch_s) begin
                cmd_r      <= command;
                op_a_idx_r <= op_a[ADDR_W-1:0];
                op_a_lo_r  <= op_a[5:0];
                op_b_r     <= op_b;
            end
            if (toggle_s) begin
                front_sel_r <= ~front_sel_r;
            end
        end
    end

    assign wpix_ok_s = ({1'b0, op_a_idx_r} < FB_WORDS_W);

    // Frame-buffer strobes and handshake outputs decoded from the state register.
    always_comb begin
        fb_re            = 1'b0;
        fb_we            = 1'b0;
        fb_addr          = {(ADDR_W + 1){1'b0}};
        fb_wdata         = 16'h0000;
        command_received = 2'b00;
        case (state_r)
            S_WPIX: begin
                fb_we    = wpix_ok_s;
                fb_addr  = {~front_sel_r, op_a_idx_r};
                fb_wdata = op_b_r;
            end
            S_RD: begin
                fb_re   = 1'b1;
                fb_addr = {~front_sel_r, idx_r};
            end
            S_WR: begin
                fb_we    = 1'b1;
                fb_addr  = {~front_sel_r, idx_r};
                fb_wdata = pixel_op(cmd_r, fb_rdata, op_a_lo_r, op_b_r[5:0]);
            end
            S_ACK:   command_received = 2'b01;
            S_FIN:   command_received = 2'b10;
            default: command_received = 2'b00;
        endcase
    end

    assign front_sel = front_sel_r;
    assign busy      = (state_r != S_IDLE);

`ifdef GPU_PERF_EN
    // Busy-cycle counter, saturating at all ones.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            perf_cycles <= 32'h0000_0000;
        end else if (busy && (perf_cycles != 32'hFFFF_FFFF)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end else begin
            perf_cycles <= perf_cycles;
        end
    end
`endif

endmodule

// File: tb/tb_gpu_cmd_unit.sv
// Directed bench for gpu_cmd_unit with a small 8-pixel frame and a behavioural frame-buffer RAM.
module tb_gpu_cmd_unit;
    localparam int FB = 8;
    localparam int AW = 4;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic [2:0]    command = 3'b111;
    logic [1:0]    command_ready = 2'b00;
    logic [1:0]    command_received;
    logic [15:0]   op_a = 16'h0000;
    logic [15:0]   op_b = 16'h0000;
    logic [AW:0]   fb_addr;
    logic          fb_re;
    logic [15:0]   fb_rdata = 16'h0000;
    logic          fb_we;
    logic [15:0]   fb_wdata;
    logic          front_sel;
    logic          busy;
`ifdef GPU_PERF_EN
    logic [31:0]   perf_cycles;
`endif

    gpu_cmd_unit #(.FB_WORDS(FB), .ADDR_W(AW)) dut (
        .Clk              (Clk),
        .Reset_n          (Reset_n),
        .command          (command),
        .command_ready    (command_ready),
        .command_received (command_received),
        .op_a             (op_a),
        .op_b             (op_b),
        .fb_addr          (fb_addr),
        .fb_re            (fb_re),
        .fb_rdata         (fb_rdata),
        .fb_we            (fb_we),
        .fb_wdata         (fb_wdata),
        .front_sel        (front_sel),
        .busy             (busy)
`ifdef GPU_PERF_EN
        ,
        .perf_cycles      (perf_cycles)
`endif
    );

    always #5 Clk = ~Clk;

    logic [15:0]   mem [0:2**(AW+1)-1];
    logic          pl_we = 1'b0;
    logic [AW:0]   pl_addr = '0;
    logic [15:0]   pl_data = 16'h0000;
    int unsigned   wr_cnt = 0;
    int            checks = 0;
    int            errors = 0;

    // Frame-buffer RAM: one-cycle read latency, write port shared with the preload path.
    always @(posedge Clk) begin
        if (fb_re) fb_rdata <= mem[fb_addr];
        if (fb_we) begin
            mem[fb_addr] <= fb_wdata;
            wr_cnt       <= wr_cnt + 1;
        end else if (pl_we) begin
            mem[pl_addr] <= pl_data;
        end
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 2**(AW+1); i++) begin
            pl_we   = 1'b1;
            pl_addr = (AW+1)'(i);
            pl_data = v;
            @(posedge Clk); #1;
        end
        pl_we = 1'b0;
    endtask

    task automatic wait_recv(input logic [1:0] want, input int limit, input string tag,
                             output int n);
        n = 0;
        do begin
            @(posedge Clk); #1;
            n++;
        end while (command_received !== want && n < limit);
        check_value({tag, " recv"}, 32'(command_received), 32'(want));
    endtask

    task automatic run_cmd(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b,
                           input int lat, input int hold, input string tag);
        int n;
        command       = c;
        op_a          = a;
        op_b          = b;
        command_ready = 2'b01;
        wait_recv(2'b01, 40, tag, n);
        check_value({tag, " lat"}, 32'(n), 32'(lat));
        for (int i = 0; i < hold; i++) begin
            @(posedge Clk); #1;
            check_value({tag, " hold"}, 32'(command_received), 32'h1);
        end
        command_ready = 2'b00;
        command       = 3'b111;
        @(posedge Clk); #1;
        check_value({tag, " rel"}, 32'(command_received), 32'h0);
        check_value({tag, " idle"}, 32'(busy), 32'h0);
    endtask

    initial begin
        int unsigned w0;
        int n;
        repeat (3) @(posedge Clk);
        #1;
        check_value("rst recv", 32'(command_received), 32'h0);
        check_value("rst re", 32'(fb_re), 32'h0);
        check_value("rst we", 32'(fb_we), 32'h0);
        check_value("rst addr", 32'(fb_addr), 32'h0);
        check_value("rst wdata", 32'(fb_wdata), 32'h0);
        check_value("rst front", 32'(front_sel), 32'h0);
        check_value("rst busy", 32'(busy), 32'h0);
`ifdef GPU_PERF_EN
        check_value("rst perf", perf_cycles, 32'h0);
`endif
        Reset_n = 1'b1;
        @(posedge Clk); #1;

        // Single pixel write, ack held while ready stays asserted.
        fill(16'h0000);
        w0 = wr_cnt;
        run_cmd(3'b000, 16'h0005, 16'hF800, 2, 2, "wpix");
        check_value("wpix count", wr_cnt - w0, 32'd1);
        check_value("wpix data", 32'(mem[21]), 32'hF800);
        check_value("wpix front", 32'(mem[5]), 32'h0000);

        w0 = wr_cnt;
        run_cmd(3'b000, 16'h0009, 16'h1111, 2, 0, "wpix_oob");
        check_value("oob count", wr_cnt - w0, 32'd0);

        // Whole-frame invert.
        fill(16'h0000);
        w0 = wr_cnt;
        run_cmd(3'b001, 16'h0000, 16'h0000, 17, 0, "invert");
        check_value("inv count", wr_cnt - w0, 32'd8);
        for (int i = 0; i < FB; i++) check_value("inv pix", 32'(mem[16+i]), 32'hFFFF);
        check_value("inv other", 32'(mem[0]), 32'h0000);
        check_value("inv beyond", 32'(mem[24]), 32'h0000);

        fill(16'hFFFF);
        run_cmd(3'b010, 16'h0000, 16'h0000, 17, 0, "grsc_w");
        check_value("grsc white", 32'(mem[16]), 32'hFFFF);
        fill(16'hF800);
        run_cmd(3'b010, 16'h0000, 16'h0000, 17, 0, "grsc_r");
        check_value("grsc red", 32'(mem[16]), 32'h39E7);
        check_value("grsc red last", 32'(mem[23]), 32'h39E7);

        fill(16'h0000);
        run_cmd(3'b011, 16'h003F, 16'h0000, 17, 0, "brtn_m1");
        check_value("brtn dark", 32'(mem[16]), 32'h0000);
        run_cmd(3'b011, 16'h0003, 16'h0000, 17, 0, "brtn_p3");
        check_value("brtn +3", 32'(mem[20]), 32'h0861);
        fill(16'hFFFF);
        run_cmd(3'b011, 16'h0001, 16'h0000, 17, 0, "brtn_p1");
        check_value("brtn sat", 32'(mem[16]), 32'hFFFF);
        run_cmd(3'b011, 16'h003F, 16'h0000, 17, 0, "brtn_m1w");
        check_value("brtn -1", 32'(mem[23]), 32'hFFDF);

        fill(16'hFFFF);
        run_cmd(3'b100, 16'h0008, 16'h0010, 17, 0, "range");
        check_value("range hi", 32'(mem[16]), 32'h4208);
        fill(16'h0000);
        run_cmd(3'b100, 16'h0014, 16'h000A, 17, 0, "range_inv");
        check_value("range lo>hi", 32'(mem[17]), 32'h2945);

        // Publish flips the target buffer.
        run_cmd(3'b110, 16'h0000, 16'h0000, 1, 0, "pub1");
        check_value("front 1", 32'(front_sel), 32'h1);
        fill(16'h0000);
        run_cmd(3'b000, 16'h0002, 16'h1234, 2, 0, "wpix_b0");
        check_value("buf0 write", 32'(mem[2]), 32'h1234);
        check_value("buf1 clean", 32'(mem[18]), 32'h0000);
        run_cmd(3'b110, 16'h0000, 16'h0000, 1, 0, "pub2");
        check_value("front 0", 32'(front_sel), 32'h0);
        run_cmd(3'b000, 16'h0003, 16'hABCD, 2, 0, "wpix_b1");
        check_value("buf1 write", 32'(mem[19]), 32'hABCD);

        w0 = wr_cnt;
        run_cmd(3'b101, 16'h0001, 16'h0001, 1, 0, "cmd101");
        run_cmd(3'b111, 16'h0001, 16'h0001, 1, 0, "nop");
        check_value("nop writes", wr_cnt - w0, 32'd0);

        // Finish request arriving mid-operation is answered only after the ack.
        fill(16'h0000);
        w0 = wr_cnt;
        command       = 3'b001;
        command_ready = 2'b01;
        @(posedge Clk); #1;
        command_ready = 2'b10;
        command       = 3'b000;
        wait_recv(2'b10, 40, "fin", n);
        check_value("fin lat", 32'(n + 1), 32'd19);
        check_value("fin writes", wr_cnt - w0, 32'd8);
        check_value("fin data", 32'(mem[16]), 32'hFFFF);
        command_ready = 2'b00;
        @(posedge Clk); #1;
        check_value("fin rel", 32'(command_received), 32'h0);

        // Reset in the middle of a frame pass.
        fill(16'h0000);
        command       = 3'b001;
        command_ready = 2'b01;
        repeat (4) @(posedge Clk);
        #1;
        Reset_n       = 1'b0;
        command_ready = 2'b00;
        w0 = wr_cnt;
        #1;
        check_value("rst mid busy", 32'(busy), 32'h0);
        check_value("rst mid we", 32'(fb_we), 32'h0);
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        repeat (20) @(posedge Clk);
        #1;
        check_value("rst mid writes", wr_cnt - w0, 32'd0);
        check_value("rst mid recv", 32'(command_received), 32'h0);
        check_value("rst mid front", 32'(front_sel), 32'h0);
`ifdef GPU_PERF_EN
        check_value("perf idle", perf_cycles, 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
